// File: rtl/input_conditioner_if.sv
// Purpose: bundles the per-channel pin inputs and conditioned outputs of input_conditioner.
// Latency: none (wires only).
// Backpressure: none; every output is valid on every cycle.
//
// Ports (CHANNELS bits each):
//   async_in - raw asynchronous inputs (driven by the pin side)
//   sync_out - synchronised, not debounced
//   level    - debounced, accepted level
//   rise     - one-cycle pulse on an accepted 0->1 change
//   fall     - one-cycle pulse on an accepted 1->0 change
interface input_conditioner_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] async_in;
    logic [CHANNELS-1:0] sync_out;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    // Pin side: drives the raw lines, observes conditioned results.
    modport master (
        output async_in,
        input  sync_out,
        input  level,
        input  rise,
        input  fall
    );

    // Conditioner side.
    modport slave (
        input  async_in,
        output sync_out,
        output level,
        output rise,
        output fall
    );
endinterface

// File: rtl/conditioner_channel.sv
// Purpose: one input line: N-flop synchroniser, stability-count debouncer, rise/fall pulses.
// Latency: level/pulse update SYNC_STAGES+DEBOUNCE_CYCLES edges after stage 1 samples a change.
// Backpressure: none; free-running, outputs valid every cycle.
//
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   async_in  - raw asynchronous input bit
//   sync_out  - last synchroniser stage
//   level     - debounced level
//   rise/fall - registered one-cycle pulses on accepted level changes
module conditioner_channel #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;     // bit 0 is stage 1
    logic [CNT_W-1:0]       cnt_q;
    logic                   in_clean;

    // Only a definite 1 counts as 1, so an X/Z pin enters the chain as 0 in
    // simulation; synthesis treats the case-equality as a plain compare.
    assign in_clean = (async_in === 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_clean};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // The counter only runs while sync_out disagrees with level; any agreeing
    // cycle (a glitch ending) throws the partial count away. Reaching the
    // last count accepts the new level and clears, so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= RESET_VAL;
            cnt_q <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_out == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level <= sync_out;
                cnt_q <= '0;
                rise  <= sync_out;
                fall  <= ~sync_out;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/input_conditioner.sv
// Purpose: multi-channel pin front end; one independent conditioner_channel per line.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from first stage-1 sample to level/pulse.
// Backpressure: none; outputs are registered and valid every cycle.
//
// Ports:
//   clk  - single rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - input_conditioner_if.slave: async_in in; sync_out, level, rise, fall out
module input_conditioner #(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VAL       = '0
) (
    input  logic                clk,
    input  logic                rst,
    input_conditioner_if.slave  bus
);
    // Illegal parameter sets stop elaboration instead of building a broken chain.
    if (CHANNELS < 1) begin : g_bad_channels
        $error("input_conditioner: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [CHANNELS-1:0] sync_vec;
    logic [CHANNELS-1:0] level_vec;
    logic [CHANNELS-1:0] rise_vec;
    logic [CHANNELS-1:0] fall_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        conditioner_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[i])
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .async_in (bus.async_in[i]),
            .sync_out (sync_vec[i]),
            .level    (level_vec[i]),
            .rise     (rise_vec[i]),
            .fall     (fall_vec[i])
        );
    end

    assign bus.sync_out = sync_vec;
    assign bus.level    = level_vec;
    assign bus.rise     = rise_vec;
    assign bus.fall     = fall_vec;
endmodule

// File: tb/tb_input_conditioner.sv
// Purpose: scoreboard bench for input_conditioner (default config and a 3-stage/1-cycle/1010 config).
// Latency: expected pulses carry the absolute edge number at which they must appear.
// Backpressure: none.
module tb_input_conditioner;
    typedef struct {
        int unsigned cyc;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  level;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    ev_t         q_a[$];
    ev_t         q_b[$];
    ev_t         ea;
    ev_t         eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    input_conditioner_if #(.CHANNELS(4)) bus_a ();
    input_conditioner_if #(.CHANNELS(4)) bus_b ();

    input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'b0000)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_VAL(4'b1010)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_a(input int unsigned at, input logic [3:0] r, input logic [3:0] f,
                            input logic [3:0] l);
        ev_t e;
        e.cyc = at; e.rise = r; e.fall = f; e.level = l;
        q_a.push_back(e);
    endtask

    task automatic expect_b(input int unsigned at, input logic [3:0] r, input logic [3:0] f,
                            input logic [3:0] l);
        ev_t e;
        e.cyc = at; e.rise = r; e.fall = f; e.level = l;
        q_b.push_back(e);
    endtask

    // Monitors: any pulse must match the next scoreboard entry, including its edge number.
    always @(negedge clk) begin
        if (!rst && ((bus_a.rise | bus_a.fall) != 4'b0)) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_pulse", {24'h0, bus_a.rise, bus_a.fall}, 32'h0);
            end else begin
                ea = q_a.pop_front();
                chk("a_pulse_cycle", ea.cyc == cyc ? 32'h1 : cyc, ea.cyc == cyc ? 32'h1 : ea.cyc);
                chk("a_rise", bus_a.rise, ea.rise);
                chk("a_fall", bus_a.fall, ea.fall);
                chk("a_level", bus_a.level, ea.level);
                chk("a_rise_and_fall", bus_a.rise & bus_a.fall, 4'b0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ((bus_b.rise | bus_b.fall) != 4'b0)) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_pulse", {24'h0, bus_b.rise, bus_b.fall}, 32'h0);
            end else begin
                eb = q_b.pop_front();
                chk("b_pulse_cycle", eb.cyc == cyc ? 32'h1 : cyc, eb.cyc == cyc ? 32'h1 : eb.cyc);
                chk("b_rise", bus_b.rise, eb.rise);
                chk("b_fall", bus_b.fall, eb.fall);
                chk("b_level", bus_b.level, eb.level);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus_a.async_in = 4'b1111;
        bus_b.async_in = 4'b1010;

        // 1: reset holds everything at RESET_VAL regardless of inputs.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_a_quiet_in_reset",
                {16'h0, bus_a.sync_out, bus_a.level, bus_a.rise, bus_a.fall}, 32'h0);
            chk("t1_b_level_reset", bus_b.level, 4'b1010);
        end
        chk("t1_b_sync_reset", bus_b.sync_out, 4'b1010);
        expect_a(cyc + 6, 4'b1111, 4'b0000, 4'b1111);
        rst = 1'b0;
        tick(5);
        chk("t1_level_before_edge6", bus_a.level, 4'b0000);
        tick(1);
        chk("t1_level_at_edge6", bus_a.level, 4'b1111);
        tick(3);
        expect_a(cyc + 6, 4'b0000, 4'b1111, 4'b0000);
        bus_a.async_in = 4'b0000;
        tick(8);

        // 2: single-channel rise then fall with full latency.
        expect_a(cyc + 6, 4'b0001, 4'b0000, 4'b0001);
        bus_a.async_in = 4'b0001;
        tick(1);
        chk("t2_sync_edge1", bus_a.sync_out, 4'b0000);
        tick(1);
        chk("t2_sync_edge2", bus_a.sync_out, 4'b0001);
        tick(3);
        chk("t2_level_edge5", bus_a.level, 4'b0000);
        tick(1);
        chk("t2_level_edge6", bus_a.level, 4'b0001);
        tick(3);
        expect_a(cyc + 6, 4'b0000, 4'b0001, 4'b0000);
        bus_a.async_in = 4'b0000;
        tick(9);

        // 3: a 3-cycle glitch is rejected; a 4-cycle one is accepted.
        bus_a.async_in = 4'b0010;
        tick(3);
        chk("t3_glitch_sync", bus_a.sync_out, 4'b0010);
        bus_a.async_in = 4'b0000;
        tick(9);
        chk("t3_glitch_level", bus_a.level, 4'b0000);
        expect_a(cyc + 6, 4'b0010, 4'b0000, 4'b0010);
        bus_a.async_in = 4'b0010;
        tick(4);
        expect_a(cyc + 6, 4'b0000, 4'b0010, 4'b0000);
        bus_a.async_in = 4'b0000;
        tick(5);
        chk("t3_level_held", bus_a.level, 4'b0010);
        tick(1);
        chk("t3_level_fell", bus_a.level, 4'b0000);
        tick(3);

        // 4: simultaneous rise on ch2 and fall on ch3.
        expect_a(cyc + 6, 4'b1000, 4'b0000, 4'b1000);
        bus_a.async_in = 4'b1000;
        tick(8);
        expect_a(cyc + 6, 4'b0100, 4'b1000, 4'b0100);
        bus_a.async_in = 4'b0100;
        tick(8);

        // 5: asynchronous reset mid-debounce, then full latency from release.
        bus_a.async_in = 4'b0101;
        tick(4);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_level", bus_a.level, 4'b0000);
        chk("t5_async_sync", bus_a.sync_out, 4'b0000);
        chk("t5_async_pulses", {bus_a.rise, bus_a.fall}, 8'h00);
        @(negedge clk);
        tick(1);
        expect_a(cyc + 6, 4'b0101, 4'b0000, 4'b0101);
        rst = 1'b0;
        tick(5);
        chk("t5_level_before_edge6", bus_a.level, 4'b0000);
        tick(1);
        chk("t5_level_at_edge6", bus_a.level, 4'b0101);
        tick(3);

        // 6: 3 stages, 1 debounce cycle, reset 1010; X on ch1 is taken as 0.
        expect_b(cyc + 4, 4'b0001, 4'b0010, 4'b1001);
        bus_b.async_in = 4'b10x1;
        tick(3);
        chk("t6_sync_edge3", bus_b.sync_out, 4'b1001);
        chk("t6_level_edge3", bus_b.level, 4'b1010);
        tick(1);
        chk("t6_level_edge4", bus_b.level, 4'b1001);
        tick(6);

        chk("a_queue_drained", q_a.size(), 32'h0);
        chk("b_queue_drained", q_b.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
